alarm_ring_controller: RTL and testbench
========================================

Name: alarm_ring_controller

Overview:
- Sequences the user-facing alarm behaviour on top of the alarm comparator.
- Consumes the comparator's level-type match signal (high for the whole matching minute) and produces a beep pattern for the buzzer.
- Manages snooze, dismiss, ring timeout and re-arm.
- Sits between the alarm comparator, the debounced button block and the buzzer/LED drivers; uses the 1 Hz tick from the timekeeping counter.

Parameters:
- SNOOZE_MIN, 5: snooze duration in minutes; timer loads SNOOZE_MIN*60 seconds.
- RING_TIMEOUT_S, 60: seconds of unattended ringing before auto-snooze or auto-stop.
- MAX_SNOOZE, 3: maximum snoozes per alarm event; range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- sec_tick  input  1  one-cycle pulse, once per second, synchronous to clk
- alarm_trigger  input  1  level from comparator; high while current hh:mm equals alarm hh:mm
- alarm_enable  input  1  user alarm on/off switch, level
- snooze_btn  input  1  one-cycle pulse, debounced upstream
- dismiss_btn  input  1  one-cycle pulse, debounced upstream
- buzzer  output  1  buzzer drive
- ringing  output  1  high in RINGING
- snoozing  output  1  high in SNOOZE
- snooze_count  output  4  snoozes used in the current event
- snooze_left_s  output  $clog2(SNOOZE_MIN*60+1)  seconds remaining in SNOOZE; 0 otherwise

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
- Values in reset: state=IDLE, buzzer=0, ringing=0, snoozing=0, snooze_count=0, snooze_left_s=0, ring_cnt=0.
- Edge register: trig_q resets to 1, so a trigger already high at reset release does not ring.
- Edge detect: trig_rise = alarm_trigger & ~trig_q, with trig_q registered every cycle.
- Outputs: all outputs are registered or decoded from registered state; there are no combinational paths from inputs.

States and transitions (evaluated per clk):
- IDLE: if trig_rise & alarm_enable, go to RINGING; clear ring_cnt.
- RINGING, checked in priority order:
  1. dismiss_btn, or alarm_enable=0: go to WAIT_CLEAR.
  2. snooze_btn with snooze_count<MAX_SNOOZE: go to SNOOZE; snooze_count+1; snooze_left_s=SNOOZE_MIN*60.
  3. snooze_btn with snooze_count==MAX_SNOOZE: ignored; stay RINGING.
  4. sec_tick with ring_cnt==RING_TIMEOUT_S-1: auto-snooze (same actions as rule 2) if snooze_count<MAX_SNOOZE, else go to WAIT_CLEAR.
  5. Otherwise, sec_tick increments ring_cnt.
- SNOOZE:
  - dismiss_btn, or alarm_enable=0: go to WAIT_CLEAR.
  - sec_tick with snooze_left_s==1: go to RINGING; snooze_left_s=0; ring_cnt=0.
  - Otherwise, sec_tick decrements snooze_left_s.
  - snooze_btn is ignored.
- WAIT_CLEAR:
  - On entry: snooze_count=0, snooze_left_s=0.
  - Go to IDLE when alarm_trigger==0. This blocks re-ring within the same matching minute.
- Buzzer pattern: in RINGING, buzzer = ~ring_cnt[0] (1 s on / 1 s off, starting on). buzzer=0 in all other states.
- Latency: trig_rise sampled at edge N gives ringing=1 and buzzer=1 after edge N. Button pulse at edge N takes effect after edge N.
- Simultaneous events:
  - dismiss+snooze: dismiss wins.
  - snooze+sec_tick at timeout: snooze wins; counts as one snooze.
  - trig_rise while SNOOZE or WAIT_CLEAR: ignored.
- Snooze re-ring is timer-driven and independent of alarm_trigger, so it works after the matching minute has ended.
- alarm_enable going low mid-ring or mid-snooze silences the buzzer on the next edge.
- Asserting rst mid-operation returns the block to reset values immediately. trig_q=1 after reset, so no spurious ring.
- Width rule: the ring_cnt width is $clog2(RING_TIMEOUT_S). snooze_left_s never underflows.

Test Plan:
Test parameters: SNOOZE_MIN=1, RING_TIMEOUT_S=4, MAX_SNOOZE=2. Drive sec_tick every 10 clks.
1. Basic ring and dismiss: enable=1, raise trigger.
   - Expect ringing=1, buzzer=1 next edge; buzzer toggles each sec_tick.
   - dismiss gives WAIT_CLEAR with buzzer=0.
   - Hold trigger high: no re-ring. Drop trigger: IDLE.
2. Snooze cycle: ring, then snooze_btn.
   - Expect snoozing=1, snooze_left_s=60, snooze_count=1.
   - After 60 ticks: ringing=1, snooze_left_s=0, even with trigger already low.
3. Snooze limit: snooze twice, ring again, press snooze a third time.
   - Third press ignored: remains RINGING, snooze_count=2.
   - At the 4th tick: timeout gives WAIT_CLEAR, snooze_count=0.
4. Timeout auto-snooze: ring with no buttons.
   - After 4 ticks: SNOOZE, snooze_count=1, snooze_left_s=60.
5. Simultaneous events:
   - dismiss+snooze in the same cycle: WAIT_CLEAR.
   - alarm_enable=0 during SNOOZE: WAIT_CLEAR; buzzer stays 0.
   - enable=0 at trig_rise: no ring.
6. Reset:
   - Assert rst mid-RINGING: all outputs 0 asynchronously.
   - Release rst with trigger held high: stays IDLE until trigger falls and rises again.

Source files
------------

// File: rtl/alarm_ring_controller.sv
// Alarm ring sequencer: turns the comparator match level into a beep pattern with snooze/dismiss/timeout.
// Latency: a trigger rise or button pulse sampled at edge N is reflected on the outputs right after edge N.
// Backpressure: none; single-cycle pulse inputs are consumed on the cycle they arrive.
module alarm_ring_controller #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3,
  localparam int SNZ_W = $clog2(SNOOZE_MIN*60+1),
  localparam int RC_W  = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sec_tick,
  input  logic             alarm_trigger,
  input  logic             alarm_enable,
  input  logic             snooze_btn,
  input  logic             dismiss_btn,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozing,
  output logic [3:0]       snooze_count,
  output logic [SNZ_W-1:0] snooze_left_s
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_RINGING    = 2'd1;
  localparam logic [1:0] S_SNOOZE     = 2'd2;
  localparam logic [1:0] S_WAIT_CLEAR = 2'd3;

  localparam logic [SNZ_W-1:0] SNOOZE_LOAD = SNZ_W'(SNOOZE_MIN*60);
  localparam logic [RC_W-1:0]  RING_LAST   = RC_W'(RING_TIMEOUT_S-1);
  localparam logic [3:0]       SNOOZE_MAX  = 4'(MAX_SNOOZE);

  logic [1:0]       state, state_d;
  logic [RC_W-1:0]  ring_cnt, ring_cnt_d;
  logic [3:0]       count_d;
  logic [SNZ_W-1:0] left_d;
  logic             trig_q;
  logic             trig_rise;
  logic             can_snooze;
  logic             enter_snooze;
  logic             enter_wait;
  logic             stop_req;

  // Rising edge of the comparator level; trig_q resets high so a match already
  // in progress when reset releases is not treated as a new alarm.
  assign trig_rise  = alarm_trigger & ~trig_q;
  assign can_snooze = (snooze_count < SNOOZE_MAX);
  assign stop_req   = dismiss_btn | ~alarm_enable;

  // Track the previous trigger level every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_q <= 1'b1;
    end else begin
      trig_q <= alarm_trigger;
    end
  end

  // Next-state and counter updates. Events are resolved in priority order:
  // stop (dismiss / disable) beats snooze, which beats the second tick.
  always_comb begin
    state_d      = state;
    ring_cnt_d   = ring_cnt;
    count_d      = snooze_count;
    left_d       = snooze_left_s;
    enter_snooze = 1'b0;
    enter_wait   = 1'b0;

    case (state)
      S_IDLE: begin
        if (trig_rise && alarm_enable) begin
          state_d    = S_RINGING;
          ring_cnt_d = '0;
        end
      end

      S_RINGING: begin
        if (stop_req) begin
          enter_wait = 1'b1;
        end else if (snooze_btn && can_snooze) begin
          enter_snooze = 1'b1;
        end else if (sec_tick) begin
          // A snooze press past the limit has no effect, so the tick still counts.
          if (ring_cnt == RING_LAST) begin
            if (can_snooze) begin
              enter_snooze = 1'b1;
            end else begin
              enter_wait = 1'b1;
            end
          end else begin
            ring_cnt_d = ring_cnt + RC_W'(1);
          end
        end
      end

      S_SNOOZE: begin
        if (stop_req) begin
          enter_wait = 1'b1;
        end else if (sec_tick) begin
          // Re-ring is purely timer driven; the trigger level plays no part here.
          if (snooze_left_s == SNZ_W'(1)) begin
            state_d    = S_RINGING;
            left_d     = '0;
            ring_cnt_d = '0;
          end else if (snooze_left_s != '0) begin
            left_d = snooze_left_s - SNZ_W'(1);
          end
        end
      end

      S_WAIT_CLEAR: begin
        // Hold here until the matching minute ends so the same minute cannot re-ring.
        if (!alarm_trigger) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_snooze) begin
      state_d    = S_SNOOZE;
      count_d    = snooze_count + 4'd1;
      left_d     = SNOOZE_LOAD;
      ring_cnt_d = '0;
    end

    if (enter_wait) begin
      state_d    = S_WAIT_CLEAR;
      count_d    = '0;
      left_d     = '0;
      ring_cnt_d = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      ring_cnt      <= '0;
      snooze_count  <= '0;
      snooze_left_s <= '0;
    end else begin
      state         <= state_d;
      ring_cnt      <= ring_cnt_d;
      snooze_count  <= count_d;
      snooze_left_s <= left_d;
    end
  end

  // Outputs decode registered state only; the buzzer starts on and toggles each second.
  always_comb begin
    ringing  = (state == S_RINGING);
    snoozing = (state == S_SNOOZE);
    buzzer   = (state == S_RINGING) & ~ring_cnt[0];
  end

endmodule

// File: tb/tb_alarm_ring_controller.sv
module tb_alarm_ring_controller;

  localparam int SNOOZE_MIN     = 1;
  localparam int RING_TIMEOUT_S = 4;
  localparam int MAX_SNOOZE     = 2;
  localparam int SNZ_W          = $clog2(SNOOZE_MIN*60+1);

  logic             clk;
  logic             rst;
  logic             sec_tick;
  logic             alarm_trigger;
  logic             alarm_enable;
  logic             snooze_btn;
  logic             dismiss_btn;
  logic             buzzer;
  logic             ringing;
  logic             snoozing;
  logic [3:0]       snooze_count;
  logic [SNZ_W-1:0] snooze_left_s;

  int n_cmp;
  int n_bad;

  alarm_ring_controller #(
    .SNOOZE_MIN(SNOOZE_MIN),
    .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sec_tick(sec_tick),
    .alarm_trigger(alarm_trigger),
    .alarm_enable(alarm_enable),
    .snooze_btn(snooze_btn),
    .dismiss_btn(dismiss_btn),
    .buzzer(buzzer),
    .ringing(ringing),
    .snoozing(snoozing),
    .snooze_count(snooze_count),
    .snooze_left_s(snooze_left_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0=idle 1=ringing 2=snoozing 3=waiting for trigger to clear.
  int m_mode;
  int m_secs;   // whole seconds spent ringing in the current ring period
  int m_cnt;
  int m_left;
  bit m_prev;

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_cnt = 0; m_left = 0; m_prev = 1'b1;
  endtask

  task automatic model_stop();
    m_mode = 3; m_cnt = 0; m_left = 0;
  endtask

  task automatic model_snooze();
    m_mode = 2; m_cnt = m_cnt + 1; m_left = SNOOZE_MIN * 60;
  endtask

  task automatic model_step(input bit trig, input bit en, input bit snz, input bit dis, input bit tick);
    bit rise;
    rise   = trig && !m_prev;
    m_prev = trig;
    case (m_mode)
      0: if (rise && en) begin m_mode = 1; m_secs = 0; end
      1: begin
        if (dis || !en) model_stop();
        else if (snz && m_cnt < MAX_SNOOZE) model_snooze();
        else if (tick) begin
          m_secs = m_secs + 1;
          if (m_secs == RING_TIMEOUT_S) begin
            if (m_cnt < MAX_SNOOZE) model_snooze();
            else model_stop();
          end
        end
      end
      2: begin
        if (dis || !en) model_stop();
        else if (tick) begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_mode = 1; m_secs = 0; end
        end
      end
      default: if (!trig) m_mode = 0;
    endcase
  endtask

  function automatic logic [12:0] pack(input bit r, input bit s, input bit b, input int cnt, input int left);
    logic [3:0] c4;
    logic [5:0] l6;
    c4 = 4'(cnt);
    l6 = 6'(left);
    return {r, s, b, c4, l6};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {ringing, snoozing, buzzer, snooze_count, 6'(snooze_left_s)};
  endfunction

  function automatic logic [12:0] model_outs();
    return pack(m_mode == 1, m_mode == 2, (m_mode == 1) && (m_secs % 2 == 0), m_cnt, m_left);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp = n_cmp + 1;
    if (got != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, sample #1 later, step the model and compare.
  task automatic cyc(input bit trig, input bit en, input bit snz, input bit dis, input bit tick);
    alarm_trigger = trig;
    alarm_enable  = en;
    snooze_btn    = snz;
    dismiss_btn   = dis;
    sec_tick      = tick;
    @(posedge clk);
    #1;
    model_step(trig, en, snz, dis, tick);
    check("model_outs", int'(dut_outs()), int'(model_outs()));
  endtask

  // Run n seconds with sec_tick every 10 clocks, the tick on the last clock of each second.
  task automatic run_secs(input int n, input bit trig, input bit en);
    for (int k = 0; k < n * 10; k++) cyc(trig, en, 1'b0, 1'b0, (k % 10) == 9);
  endtask

  typedef struct {
    bit trig; bit en; bit snz; bit dis; bit tick;
    bit r; bit s; bit b; int cnt; int left;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit trig, input bit en, input bit snz, input bit dis, input bit tick,
                              input bit r, input bit s, input bit b, input int cnt, input int left);
    vec_t v;
    v.trig = trig; v.en = en; v.snz = snz; v.dis = dis; v.tick = tick;
    v.r = r; v.s = s; v.b = b; v.cnt = cnt; v.left = left;
    return v;
  endfunction

  initial begin
    bit tr, en, sz, ds;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    sec_tick = 1'b0; alarm_trigger = 1'b0; alarm_enable = 1'b0;
    snooze_btn = 1'b0; dismiss_btn = 1'b0;
    model_reset();

    //            trig en snz dis tick | ring snz buz cnt left
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 0, 1, 0,  0)); // rise -> ring, buzzer on
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 0, 0, 0,  0)); // buzzer toggles per tick
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 0, 1, 0,  0));
    tbl.push_back(mk(1, 1, 0, 1, 0,  0, 0, 0, 0,  0)); // dismiss
    tbl.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0,  0)); // trigger still high: no re-ring
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0)); // trigger falls -> idle
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 0, 1, 0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 0,  0, 1, 0, 1, 60)); // snooze
    tbl.push_back(mk(1, 1, 0, 0, 1,  0, 1, 0, 1, 59));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0)); // disable during snooze
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0)); // rise while disabled
    tbl.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0,  0)); // enabling later is not a rise
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 0, 1, 0,  0));
    tbl.push_back(mk(1, 1, 1, 1, 0,  0, 0, 0, 0,  0)); // dismiss beats snooze
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 0, 1, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 0, 1, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  0, 1, 0, 1, 60)); // timeout auto-snooze
    tbl.push_back(mk(1, 1, 1, 0, 0,  0, 1, 0, 1, 60)); // snooze ignored while snoozing
    tbl.push_back(mk(1, 1, 0, 1, 0,  0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 0,  1, 0, 1, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 0, 1, 0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  1, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 1,  0, 1, 0, 1, 60)); // snooze + timeout tick: one snooze
    tbl.push_back(mk(1, 1, 0, 1, 0,  0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0));

    // Reset state, checked while reset is held.
    #12;
    check("reset_outs", int'(dut_outs()), int'(pack(0, 0, 0, 0, 0)));
    rst = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].trig, tbl[i].en, tbl[i].snz, tbl[i].dis, tbl[i].tick);
      check($sformatf("table_row_%0d", i), int'(dut_outs()),
            int'(pack(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].cnt, tbl[i].left)));
    end

    // Full snooze period with the trigger already gone, then the snooze limit.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("snz1_left", int'(snooze_left_s), 60);
    check("snz1_count", int'(snooze_count), 1);
    cyc(0, 1, 0, 0, 0);
    run_secs(60, 1'b0, 1'b1);
    check("rering_ringing", int'(ringing), 1);
    check("rering_left", int'(snooze_left_s), 0);
    cyc(0, 1, 1, 0, 0);
    check("snz2_count", int'(snooze_count), 2);
    run_secs(60, 1'b0, 1'b1);
    check("rering2_ringing", int'(ringing), 1);
    cyc(0, 1, 1, 0, 0);
    check("snz3_ignored_ringing", int'(ringing), 1);
    check("snz3_ignored_count", int'(snooze_count), 2);
    run_secs(3, 1'b0, 1'b1);
    check("limit_still_ringing", int'(ringing), 1);
    run_secs(1, 1'b0, 1'b1);
    check("limit_timeout_outs", int'(dut_outs()), int'(pack(0, 0, 0, 0, 0)));
    cyc(0, 1, 0, 0, 0);

    // Asynchronous reset mid-ring, released with the trigger held high.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    check("pre_reset_ringing", int'(ringing), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outs", int'(dut_outs()), int'(pack(0, 0, 0, 0, 0)));
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    check("post_reset_no_ring", int'(ringing), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("post_reset_rering", int'(ringing), 1);
    cyc(1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);

    // Randomised traffic against the model, one second every 10 clocks.
    tr = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 39) == 0) tr = ~tr;
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
      sz = ($urandom_range(0, 24) == 0);
      ds = ($urandom_range(0, 119) == 0);
      cyc(tr, en, sz, ds, (k % 10) == 9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
